// File: rtl/lsu_dccm_bank_arb.sv
// DCCM port arbiter for NUM_BANKS single-ported banks: DC1 load vs store-buffer write, DC2/DC3 read pipe.
// Define RV_DCCM_STARVE_GUARD_EN to add the FORCE state that lets a starved store win a conflict.
module lsu_dccm_bank_arb #(
  parameter int DATA_W     = 32,
  parameter int ECC_W      = 7,
  parameter int NUM_BANKS  = 2,
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_freeze,
  input  logic                              i_ld_valid_dc1,
  input  logic [ADDR_W-1:0]                 i_ld_addr_dc1,
  input  logic [ADDR_W-1:0]                 i_ld_end_addr_dc1,
  output logic                              o_ld_stall_dc1,
  input  logic                              i_sb_req,
  input  logic [ADDR_W-1:0]                 i_sb_addr,
  input  logic [DATA_W+ECC_W-1:0]           i_sb_wdata,
  output logic                              o_sb_commit,
  output logic [NUM_BANKS-1:0]              o_bank_rden,
  output logic [NUM_BANKS*ADDR_W-1:0]       o_bank_rd_addr,
  output logic [NUM_BANKS-1:0]              o_bank_wren,
  output logic [ADDR_W-1:0]                 o_bank_wr_addr,
  output logic [DATA_W+ECC_W-1:0]           o_bank_wr_data,
  input  logic [NUM_BANKS*(DATA_W+ECC_W)-1:0] i_bank_rd_data,
  output logic                              o_ld_valid_dc3,
  output logic [DATA_W+ECC_W-1:0]           o_ld_data_lo_dc3,
  output logic [DATA_W+ECC_W-1:0]           o_ld_data_hi_dc3
);

  localparam int BW = $clog2(DATA_W / 8);
  localparam int BB = $clog2(NUM_BANKS);
  localparam int FW = DATA_W + ECC_W;

  logic [BB-1:0] w_lo;
  logic [BB-1:0] w_hi;
  logic [BB-1:0] w_sb_bank;
  logic          w_active;
  logic          w_conflict;
  logic          w_force;
  logic          w_sb_commit;
  logic          w_ld_issue;

  assign w_lo      = i_ld_addr_dc1[BW +: BB];
  assign w_hi      = i_ld_end_addr_dc1[BW +: BB];
  assign w_sb_bank = i_sb_addr[BW +: BB];
  assign w_active  = ~i_rst & ~i_freeze;
  assign w_conflict = i_ld_valid_dc1 & i_sb_req & ((w_sb_bank == w_lo) | (w_sb_bank == w_hi));

`ifdef RV_DCCM_STARVE_GUARD_EN
  localparam int CW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FORCE = 1'b1;

  logic [0:0]    r_state;
  logic [CW-1:0] r_starve_cnt;

  assign w_force = (r_state == ST_FORCE);

  // Counts consecutive unfrozen conflict cycles; the last one allowed hands the next conflict to the store.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
    end else if (!i_freeze) begin
      case (r_state)
        ST_IDLE: begin
          if (w_conflict) begin
            if (r_starve_cnt == CW'(STARVE_MAX - 1)) begin
              r_state      <= ST_FORCE;
              r_starve_cnt <= '0;
            end else begin
              r_starve_cnt <= r_starve_cnt + 1'b1;
            end
          end else begin
            r_starve_cnt <= '0;
          end
        end
        default: begin
          if (w_sb_commit) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
          end
        end
      endcase
    end
  end
`else
  assign w_force = 1'b0;
`endif

  assign w_sb_commit    = i_sb_req & w_active & (~w_conflict | w_force);
  assign w_ld_issue     = i_ld_valid_dc1 & w_active & ~(w_force & w_conflict);
  assign o_sb_commit    = w_sb_commit;
  assign o_ld_stall_dc1 = i_ld_valid_dc1 & ~i_rst & ~w_ld_issue;
  assign o_bank_wr_addr = w_sb_commit ? i_sb_addr : '0;
  assign o_bank_wr_data = w_sb_commit ? i_sb_wdata : '0;

  // When both halves land in one bank the start address is the one presented to it.
  always_comb begin
    o_bank_rden    = '0;
    o_bank_rd_addr = '0;
    o_bank_wren    = '0;
    if (w_ld_issue) begin
      o_bank_rden[w_hi] = 1'b1;
      o_bank_rd_addr[int'(w_hi)*ADDR_W +: ADDR_W] = i_ld_end_addr_dc1;
      o_bank_rden[w_lo] = 1'b1;
      o_bank_rd_addr[int'(w_lo)*ADDR_W +: ADDR_W] = i_ld_addr_dc1;
    end
    if (w_sb_commit) begin
      o_bank_wren[w_sb_bank] = 1'b1;
    end
  end

  logic          r_dc2_valid;
  logic [BB-1:0] r_dc2_lo;
  logic [BB-1:0] r_dc2_hi;
  logic          r_dc3_valid;
  logic [FW-1:0] r_dc3_lo;
  logic [FW-1:0] r_dc3_hi;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dc2_valid <= 1'b0;
      r_dc2_lo    <= '0;
      r_dc2_hi    <= '0;
      r_dc3_valid <= 1'b0;
      r_dc3_lo    <= '0;
      r_dc3_hi    <= '0;
    end else if (!i_freeze) begin
      r_dc2_valid <= w_ld_issue;
      r_dc2_lo    <= w_lo;
      r_dc2_hi    <= w_hi;
      r_dc3_valid <= r_dc2_valid;
      if (r_dc2_valid) begin
        r_dc3_lo <= i_bank_rd_data[int'(r_dc2_lo)*FW +: FW];
        r_dc3_hi <= i_bank_rd_data[int'(r_dc2_hi)*FW +: FW];
      end
    end
  end

  assign o_ld_valid_dc3   = r_dc3_valid;
  assign o_ld_data_lo_dc3 = r_dc3_lo;
  assign o_ld_data_hi_dc3 = r_dc3_hi;

endmodule

// File: doc/lsu_dccm_bank_arb.md
# lsu_dccm_bank_arb

Parametrised DCCM port controller for the LSU pipe, generalising the two-bank DCCM control to NUM_BANKS single-ported banks. It arbitrates each cycle between the DC1 load read (which may span two banks when unaligned) and the store-buffer write, and carries the read through a freezable DC2/DC3 pipeline. It adds a starvation guard so that continuous bank-conflicting loads cannot block store-buffer drain indefinitely. It sits between the LSU DC1 address stage, the store buffer and the DCCM bank macros.

## Interface
- DATA_W, 32: bank data width in bits; must be a multiple of 8.
- ECC_W, 7: ECC bits per bank word.
- NUM_BANKS, 2: bank count; power of two, at least 2.
- ADDR_W, 16: DCCM byte-address width.
- STARVE_MAX, 4: consecutive store-blocked cycles before a store is forced; at least 1.
- Derived values:
  - BW = log2(DATA_W/8).
  - BB = log2(NUM_BANKS).
  - FW = DATA_W+ECC_W.
  - bank(a) = a[BW+:BB].

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  pipeline freeze.
- ld_valid_dc1  in  1  load read request.
- ld_addr_dc1  in  ADDR_W  start byte address.
- ld_end_addr_dc1  in  ADDR_W  last byte address.
- ld_stall_dc1  out  1  load not issued this cycle; upstream holds it in DC1.
- sb_req  in  1  store buffer has an entry to commit.
- sb_addr  in  ADDR_W  store address (bank-aligned).
- sb_wdata  in  FW  store data with ECC.
- sb_commit  out  1  store written this cycle.
- bank_rden  out  NUM_BANKS  per-bank read enable.
- bank_rd_addr  out  NUM_BANKS*ADDR_W  per-bank read address.
- bank_wren  out  NUM_BANKS  per-bank write enable.
- bank_wr_addr  out  ADDR_W  write address.
- bank_wr_data  out  FW  write data.
- bank_rd_data  in  NUM_BANKS*FW  bank read data, valid one cycle after rden.
- ld_valid_dc3  out  1  DC3 data valid.
- ld_data_lo_dc3  out  FW  word for the start bank.
- ld_data_hi_dc3  out  FW  word for the end bank.

## Operation
- Bank selection:
  - lo = bank(ld_addr_dc1), hi = bank(ld_end_addr_dc1).
  - If lo == hi, only one bank is read and both output slots carry that bank's word.
- Conflict:
  - conflict = ld_valid_dc1 & sb_req & (bank(sb_addr) == lo | bank(sb_addr) == hi).
  - A store to a non-conflicting bank commits in the same cycle as the load.
- State machine:
  - IDLE:
    - Load wins on conflict.
    - On every cycle with conflict & ~freeze, starve_cnt increments.
    - When starve_cnt reaches STARVE_MAX-1 and conflict holds again, go to FORCE.
    - Any cycle without conflict, or any cycle with sb_commit, clears starve_cnt to 0.
  - FORCE:
    - Store wins.
    - ld_stall_dc1 = ld_valid_dc1.
    - No bank_rden is issued.
    - Return to IDLE with starve_cnt=0 on the cycle sb_commit=1.
- sb_commit = sb_req & ~freeze & (~conflict | state==FORCE).
- ld_issue = ld_valid_dc1 & ~freeze & ~(state==FORCE & conflict).
- ld_stall_dc1 = ld_valid_dc1 & ~ld_issue.
- Bank drive signals:
  - bank_rden[lo] and bank_rden[hi] are set when ld_issue.
  - bank_rd_addr for lo is ld_addr_dc1; for hi it is ld_end_addr_dc1.
  - Non-selected bank_rd_addr fields are driven 0.
- bank_wren[bank(sb_addr)] = sb_commit.
- DC2 registers: valid, lo, hi. Loaded when ~freeze.
- DC3 registers: valid, lo word, hi word. Loaded from bank_rd_data[lo]/[hi] when ~freeze.
- freeze=1: DC2/DC3 registers, state and counter all hold.
- Reset values: all outputs 0, state IDLE, starve_cnt 0, DC2/DC3 valids 0.

## Timing
- Load read latency: ld_issue in cycle T gives ld_valid_dc3 in T+2, absent freeze. Each frozen cycle adds one.
- Store commit is combinational in the same cycle as sb_req.
- Starvation bound: a conflicting store commits no later than the (STARVE_MAX+1)-th cycle of continuous conflict.
- Reset asserted mid-operation clears in-flight DC2/DC3 loads with no output pulse. The cycle after reset deassertion behaves as IDLE.

## Configuration
- RV_DCCM_STARVE_GUARD_EN defined: the FORCE state and starve_cnt are present as described above.
- RV_DCCM_STARVE_GUARD_EN undefined:
  - The state machine and counter are removed.
  - Load always wins on conflict and ld_stall_dc1 = ld_valid_dc1 & freeze.
  - All other behaviour is unchanged.

## Test plan
- NUM_BANKS=4, aligned load to addr 0x0008 (bank 2) at T, no store:
  - bank_rden=4'b0100 at T.
  - ld_valid_dc3=1 at T+2 with lo=hi=the bank-2 word.
- Unaligned load from 0x000E to 0x0011 (banks 3 and 0) together with a store to 0x0004 (bank 1):
  - bank_rden=4'b1001, bank_wren=4'b0010, sb_commit=1, ld_stall_dc1=0.
- Continuous conflicting load and store to bank 0 with STARVE_MAX=4:
  - sb_commit=0 for cycles 1-4, FORCE entered in cycle 5.
  - sb_commit=1 and ld_stall_dc1=1 in cycle 5; cycle 6 is back in IDLE.
- freeze=1 for 3 cycles starting the cycle after a load issue:
  - ld_valid_dc3 appears at T+5.
  - No bank_rden or bank_wren during the freeze.
- rst=1 while a load is in DC2:
  - ld_valid_dc3 stays 0.
  - Every output is 0 in the cycle after reset.
- Guard macro undefined, 10 cycles of bank-0 conflict:
  - sb_commit is never asserted and ld_stall_dc1 stays 0.
